// File: rtl/sig_checker.sv
// sig_checker: after end-of-test, reads a signature region from memory word by word
// and compares it against a reference table, reporting mismatch count and first failure.
module sig_checker #(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] SIG_BASE     = 'h80,
    parameter int                SIG_WORDS    = 64,
    parameter int                SETTLE       = 4,
    parameter int                TIMEOUT      = 100000,
    parameter bit                STOP_ON_FAIL = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_i,
    input  logic                               eot_i,
    output logic                               mem_req_o,
    output logic [ADDR_W-1:0]                  mem_addr_o,
    input  logic                               mem_gnt_i,
    input  logic                               mem_rvalid_i,
    input  logic [DATA_W-1:0]                  mem_rdata_i,
    output logic [$clog2(SIG_WORDS+1)-1:0]     ref_idx_o,
    input  logic [DATA_W-1:0]                  ref_data_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               pass_o,
    output logic                               timeout_o,
    output logic [$clog2(SIG_WORDS+1)-1:0]     mis_cnt_o,
    output logic [ADDR_W-1:0]                  first_addr_o,
    output logic [DATA_W-1:0]                  first_exp_o,
    output logic [DATA_W-1:0]                  first_got_o
);
    localparam int IDX_W = $clog2(SIG_WORDS + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_SETTLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state, nxt;
    logic [31:0]       cnt;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] word_addr;
    logic              take, mis, last, arm;

    assign word_addr = SIG_BASE + ADDR_W'(idx);
    assign take      = state == S_WAIT && mem_rvalid_i;
    assign mis       = mem_rdata_i !== ref_data_i;
    assign last      = idx == IDX_W'(SIG_WORDS - 1);
    assign arm       = start_i && (state == S_IDLE || state == S_DONE);

    assign mem_req_o  = state == S_REQ;
    assign mem_addr_o = state == S_REQ ? word_addr : '0;
    assign ref_idx_o  = state == S_WAIT ? idx : '0;
    assign busy_o     = state inside {S_ARMED, S_SETTLE, S_REQ, S_WAIT};
    assign done_o     = state == S_DONE;
    assign pass_o     = done_o && !timeout_o && mis_cnt_o == '0;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE: nxt = start_i ? S_ARMED : state;
            S_ARMED:        nxt = eot_i ? (SETTLE == 0 ? S_REQ : S_SETTLE)
                                : (TIMEOUT > 0 && cnt == 32'(TIMEOUT - 1)) ? S_DONE : S_ARMED;
            S_SETTLE:       nxt = cnt == 32'(SETTLE - 1) ? S_REQ : S_SETTLE;
            S_REQ:          nxt = mem_gnt_i ? S_WAIT : S_REQ;
            S_WAIT:         nxt = !take ? S_WAIT : (last || (STOP_ON_FAIL && mis)) ? S_DONE : S_REQ;
            default:        nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // cnt measures cycles spent in the current state; it restarts on every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            idx          <= '0;
            mis_cnt_o    <= '0;
            timeout_o    <= 1'b0;
            first_addr_o <= '0;
            first_exp_o  <= '0;
            first_got_o  <= '0;
        end else begin
            cnt <= nxt == state ? cnt + 32'd1 : '0;
            idx <= take ? idx + IDX_W'(1) : (state == S_REQ || state == S_WAIT) ? idx : '0;
            if (arm) begin
                mis_cnt_o    <= '0;
                timeout_o    <= 1'b0;
                first_addr_o <= '0;
                first_exp_o  <= '0;
                first_got_o  <= '0;
            end
            if (state == S_ARMED && nxt == S_DONE) timeout_o <= 1'b1;
            if (take && mis) begin
                if (mis_cnt_o != IDX_W'(SIG_WORDS)) mis_cnt_o <= mis_cnt_o + IDX_W'(1);
                if (mis_cnt_o == '0) begin
                    first_addr_o <= word_addr;
                    first_exp_o  <= ref_data_i;
                    first_got_o  <= mem_rdata_i;
                end
            end
        end
    end
endmodule
